uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- host-side controller for a UART receiver.
//   Synchronizes the receiver's done/active status, captures completed frames
//   ({error_flag, data_out}) into a show-ahead FIFO, and keeps an overrun flag
//   plus a saturating error-frame counter. Configuration writes (baud/parity)
//   are deferred while the receiver is active so the line settings never change
//   mid-frame.
// Ports:
//   clock, reset           : system clock, async active-high reset
//   rx_enable              : capture completed frames when 1
//   cfg_wr/cfg_baud/cfg_parity, cfg_busy : config write strobe/values, pending flag
//   baud_rate, parity_type : config driven to the receiver
//   active_flag, done_flag, error_flag, data_out : receiver status and payload
//   rd_valid/rd_ready/rd_data/rd_err : host read handshake (FIFO head)
//   overrun, clr_overrun   : sticky dropped-frame flag and its clear
//   err_count              : saturating count of captured frames with errors
//   fifo_level             : FIFO occupancy
module uart_rx_ctrl #(
  parameter int         DEPTH      = 4,
  parameter logic [1:0] DEF_BAUD   = 2'b00,
  parameter logic [1:0] DEF_PARITY = 2'b00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_enable,
  input  logic                     cfg_wr,
  input  logic [1:0]               cfg_baud,
  input  logic [1:0]               cfg_parity,
  output logic                     cfg_busy,
  output logic [1:0]               baud_rate,
  output logic [1:0]               parity_type,
  input  logic                     active_flag,
  input  logic                     done_flag,
  input  logic [2:0]               error_flag,
  input  logic [7:0]               data_out,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic [2:0]               rd_err,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_PEND} cfg_st_t;

  // status synchronizers and done edge detector
  logic r_done_s1, r_done_s2, r_done_d;
  logic r_act_s1, r_act_s2;
  logic [1:0] r_arm;
  logic w_act, w_done_rise, w_armed;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done_s1 <= 1'b0;
      r_done_s2 <= 1'b0;
      r_done_d  <= 1'b0;
      r_act_s1  <= 1'b0;
      r_act_s2  <= 1'b0;
      r_arm     <= 2'd0;
    end else begin
      r_done_s1 <= done_flag;
      r_done_s2 <= r_done_s1;
      r_done_d  <= r_done_s2;
      r_act_s1  <= active_flag;
      r_act_s2  <= r_act_s1;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
    end
  end

  // Blank edges for the first 3 clocks after reset so a done_flag that was
  // already high through reset is not mistaken for a new frame.
  assign w_armed     = (r_arm == 2'd3);
  assign w_act       = r_act_s2;
  assign w_done_rise = r_done_s2 & ~r_done_d;

  // receive FIFO
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_err_cnt;
  logic          r_ovr;
  logic          w_wr_req, w_pop, w_full, w_wr_acc, w_drop;

  assign w_wr_req = w_done_rise & rx_enable & w_armed;
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_pop    = rd_valid & rd_ready;
  // a pop on the same clock frees the slot, so a full FIFO can still accept
  assign w_wr_acc = w_wr_req & (~w_full | w_pop);
  assign w_drop   = w_wr_req & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wptr] <= {error_flag, data_out};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_ovr     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop)           r_ovr <= 1'b1;
      else if (clr_overrun) r_ovr <= 1'b0;
      if (w_wr_req && error_flag != 3'd0 && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign fifo_level = r_level;
  assign rd_valid   = (r_level != '0);
  assign rd_data    = rd_valid ? r_mem[r_rptr][7:0]  : 8'd0;
  assign rd_err     = rd_valid ? r_mem[r_rptr][10:8] : 3'd0;
  assign overrun    = r_ovr;
  assign err_count  = r_err_cnt;

  // configuration FSM: apply immediately when idle, otherwise hold the last
  // written values until the receiver goes inactive
  cfg_st_t    r_state;
  logic       r_busy;
  logic [1:0] r_baud, r_par, r_lat_baud, r_lat_par;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_baud     <= DEF_BAUD;
      r_par      <= DEF_PARITY;
      r_lat_baud <= DEF_BAUD;
      r_lat_par  <= DEF_PARITY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_wr) begin
            if (!w_act) begin
              r_baud <= cfg_baud;
              r_par  <= cfg_parity;
            end else begin
              r_lat_baud <= cfg_baud;
              r_lat_par  <= cfg_parity;
              r_state    <= S_PEND;
              r_busy     <= 1'b1;
            end
          end
        end
        S_PEND: begin
          if (!w_act) begin
            // a write landing on the release clock is the newest, so it wins
            r_baud  <= cfg_wr ? cfg_baud   : r_lat_baud;
            r_par   <= cfg_wr ? cfg_parity : r_lat_par;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (cfg_wr) begin
            r_lat_baud <= cfg_baud;
            r_lat_par  <= cfg_parity;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_busy    = r_busy;
  assign baud_rate   = r_baud;
  assign parity_type = r_par;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_enable = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_baud = 2'b00, cfg_parity = 2'b00;
  logic       cfg_busy;
  logic [1:0] baud_rate, parity_type;
  logic       active_flag = 1'b0, done_flag = 1'b0;
  logic [2:0] error_flag = 3'd0;
  logic [7:0] data_out = 8'd0;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic [2:0] rd_err;
  logic       overrun, clr_overrun = 1'b0;
  logic [7:0] err_count;
  logic [$clog2(DEPTH):0] fifo_level;

  logic rdy_mode = 1'b0, rdy_dir = 1'b0, rdy_rnd = 1'b0;
  assign rd_ready = rdy_mode ? rdy_rnd : rdy_dir;

  uart_rx_ctrl #(.DEPTH(DEPTH), .DEF_BAUD(2'b00), .DEF_PARITY(2'b00)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable),
    .cfg_wr(cfg_wr), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
    .cfg_busy(cfg_busy), .baud_rate(baud_rate), .parity_type(parity_type),
    .active_flag(active_flag), .done_flag(done_flag), .error_flag(error_flag),
    .data_out(data_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_err(rd_err), .overrun(overrun),
    .clr_overrun(clr_overrun), .err_count(err_count), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  // reference model: frames the host should read, in order, plus flags
  logic [10:0] exp_q[$];
  bit          exp_ovr  = 1'b0;
  int          exp_errc = 0;
  bit          mon_en   = 1'b0;
  int          checks   = 0;
  int          errors   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // a captured frame is queued unless the FIFO is full (host pops are already
  // removed from the model by the time the capture clock is evaluated)
  task automatic model_capture(input logic [7:0] d, input logic [2:0] e);
    if (e != 3'd0 && exp_errc < 255) exp_errc++;
    if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back({e, d});
  endtask

  // monitor: sample mid-cycle; a pop happens on the next rising edge
  initial begin
    logic [10:0] f;
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        chk("rd_valid", int'(rd_valid), int'(exp_q.size() != 0));
        chk("fifo_level", int'(fifo_level), exp_q.size());
        chk("overrun", int'(overrun), int'(exp_ovr));
        chk("err_count", int'(err_count), exp_errc);
        if (rd_valid && rd_ready && exp_q.size() != 0) begin
          f = exp_q.pop_front();
          chk("rd_data", int'(rd_data), int'(f[7:0]));
          chk("rd_err", int'(rd_err), int'(f[10:8]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      rdy_rnd = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic [2:0] e, input bit pulse_rdy);
    repeat (2) @(posedge clock); #1;
    data_out = d; error_flag = e; done_flag = 1'b1;
    repeat (2) @(posedge clock); #1;
    if (pulse_rdy) rdy_dir = 1'b1;  // pop lands on the capture clock
    @(posedge clock); #1;
    if (pulse_rdy) rdy_dir = 1'b0;
    if (rx_enable) model_capture(d, e);
    done_flag = 1'b0;
  endtask

  task automatic drain();
    rdy_dir = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    rdy_dir = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    chk("drain_rd_valid", int'(rd_valid), 0);
  endtask

  task automatic clr_ovr();
    clr_overrun = 1'b1;
    @(posedge clock); #1;
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    chk("overrun_clr", int'(overrun), 0);
  endtask

  task automatic cfg_write(input logic [1:0] b, input logic [1:0] p);
    cfg_baud = b; cfg_parity = p; cfg_wr = 1'b1;
    @(posedge clock); #1;
    cfg_wr = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clock); #1;
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_err", int'(rd_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_cfg_busy", int'(cfg_busy), 0);
    chk("rst_baud", int'(baud_rate), 0);
    chk("rst_parity", int'(parity_type), 0);
    reset = 1'b0;
    repeat (5) @(posedge clock); #1;
    mon_en = 1'b1;

    // single frame, 3-clock latency, one-clock read
    rx_enable = 1'b1;
    send_frame(8'hA5, 3'd0, 1'b0);
    chk("lat_rd_valid", int'(rd_valid), 1);
    chk("lat_rd_data", int'(rd_data), 8'hA5);
    chk("lat_rd_err", int'(rd_err), 0);
    rdy_dir = 1'b1;
    @(posedge clock); #1;
    rdy_dir = 1'b0;
    chk("pop_rd_valid", int'(rd_valid), 0);

    // disabled capture is ignored entirely
    rx_enable = 1'b0;
    send_frame(8'h3C, 3'd5, 1'b0);
    chk("dis_level", int'(fifo_level), 0);
    chk("dis_err_count", int'(err_count), 0);
    rx_enable = 1'b1;

    // overrun: five frames, no reads
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 3'd0, 1'b0);
    chk("ovr_level", int'(fifo_level), 4);
    chk("ovr_flag", int'(overrun), 1);
    drain();
    clr_ovr();

    // full with a pop on the capture clock: accepted, no overrun
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 3'd0, 1'b0);
    send_frame(8'h05, 3'd0, 1'b1);
    chk("fullpop_level", int'(fifo_level), 4);
    chk("fullpop_ovr", int'(overrun), 0);
    drain();

    // error counter saturation
    rdy_dir = 1'b1;
    for (int k = 0; k < 300; k++) send_frame(8'(k), 3'b010, 1'b0);
    drain();
    chk("errc_sat", int'(err_count), 255);

    // randomized traffic with random host reads
    rdy_mode = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [2:0] e;
      rx_enable = ($urandom_range(0, 4) != 0);
      e = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      send_frame(8'($urandom), e, 1'b0);
      if ($urandom_range(0, 7) == 0) clr_ovr();
    end
    rdy_mode = 1'b0;
    rx_enable = 1'b1;
    drain();
    clr_ovr();

    // deferred configuration while receiver active, last write wins
    active_flag = 1'b1;
    repeat (3) @(posedge clock); #1;
    cfg_write(2'b11, 2'b01);
    @(posedge clock); #1;
    chk("pend_busy", int'(cfg_busy), 1);
    chk("pend_baud_hold", int'(baud_rate), 0);
    cfg_write(2'b01, 2'b10);
    chk("pend2_busy", int'(cfg_busy), 1);
    chk("pend2_parity_hold", int'(parity_type), 0);
    active_flag = 1'b0;
    repeat (2) @(posedge clock); #1;
    chk("rel_baud_hold", int'(baud_rate), 0);
    @(posedge clock); #1;
    chk("rel_baud", int'(baud_rate), 1);
    chk("rel_parity", int'(parity_type), 2);
    chk("rel_busy", int'(cfg_busy), 0);

    // idle write applies on the next clock
    cfg_write(2'b10, 2'b11);
    chk("idle_baud", int'(baud_rate), 2);
    chk("idle_parity", int'(parity_type), 3);
    chk("idle_busy", int'(cfg_busy), 0);

    // reset with buffered entries and a pending config
    send_frame(8'h11, 3'd0, 1'b0);
    send_frame(8'h22, 3'd1, 1'b0);
    active_flag = 1'b1;
    repeat (3) @(posedge clock); #1;
    cfg_write(2'b01, 2'b01);
    chk("pre_rst_busy", int'(cfg_busy), 1);
    chk("pre_rst_level", int'(fifo_level), 2);
    reset = 1'b1;
    exp_q.delete(); exp_ovr = 1'b0; exp_errc = 0;
    #1;
    chk("arst_level", int'(fifo_level), 0);
    chk("arst_rd_valid", int'(rd_valid), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_busy", int'(cfg_busy), 0);
    chk("arst_baud", int'(baud_rate), 0);
    chk("arst_err_count", int'(err_count), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    active_flag = 1'b0;
    repeat (5) @(posedge clock); #1;
    chk("post_rst_baud", int'(baud_rate), 0);
    chk("post_rst_parity", int'(parity_type), 0);
    chk("post_rst_busy", int'(cfg_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
